// File: rtl/rx_deserialiser.sv
// rx_deserialiser
//
// Purpose:
//   Turns the bit-serial receive stream coming out of the Miller decoder into
//   a byte stream for the framing logic. Bits arrive LSB first. With
//   PARITY_EN=1 every ninth bit is an odd-parity bit: it is checked, then
//   dropped. A trailing partial byte is reported on out_data_bits together
//   with out_eoc.
//
// Ports:
//   clk             in   system clock
//   rst_n           in   asynchronous active-low reset
//   in_soc          in   bit stream start of comms (1-tick pulse)
//   in_eoc          in   bit stream end of comms (1-tick pulse)
//   in_data         in   received bit, valid when in_data_valid
//   in_data_valid   in   in_data qualifier (1-tick pulse)
//   in_error        in   decoder error, only together with in_eoc
//   out_soc         out  byte stream start of comms
//   out_eoc         out  byte stream end of comms
//   out_data        out  received byte, bit 0 = first bit received
//   out_data_valid  out  out_data qualifier
//   out_data_bits   out  valid bits in out_data (0 = 8, 1-7 = partial, eoc only)
//   out_error       out  frame error, only together with out_eoc
//
// Every output is registered, so each output event appears one clock after
// the input event that caused it.

module rx_deserialiser #(
    parameter bit PARITY_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_soc,
    input  logic       in_eoc,
    input  logic       in_data,
    input  logic       in_data_valid,
    input  logic       in_error,
    output logic       out_soc,
    output logic       out_eoc,
    output logic [7:0] out_data,
    output logic       out_data_valid,
    output logic [2:0] out_data_bits,
    output logic       out_error
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RX   = 1'b1
    } state_t;

    state_t      r_state, w_state_next;
    logic [3:0]  r_bit_cnt, w_bit_cnt_next;
    logic        r_err_flag, w_err_flag_next;
    logic [7:0]  r_shreg, w_shreg_next;

    logic        r_soc, w_soc_next;
    logic        r_eoc, w_eoc_next;
    logic        r_dv, w_dv_next;
    logic        r_error, w_error_next;
    logic [7:0]  r_data, w_data_next;
    logic [2:0]  r_data_bits, w_data_bits_next;

    logic [7:0]  w_mask;
    logic        w_parity_ok;
    logic        w_frame_err;

    // Keeps only the bits received so far; a partial byte must report its
    // unused MSBs as zero even if the shift register still holds an older byte.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_mask
            assign w_mask[gi] = (r_bit_cnt > 4'(gi));
        end
    endgenerate

    // Odd parity: the parity bit makes the total count of ones odd.
    assign w_parity_ok = (in_data == ~^r_shreg);

    // A complete byte still waiting for its parity bit at eoc is an error.
    assign w_frame_err = r_err_flag | in_error | (PARITY_EN && (r_bit_cnt == 4'd8));

    always_comb begin
        w_state_next     = r_state;
        w_bit_cnt_next   = r_bit_cnt;
        w_err_flag_next  = r_err_flag;
        w_shreg_next     = r_shreg;
        w_soc_next       = 1'b0;
        w_eoc_next       = 1'b0;
        w_dv_next        = 1'b0;
        w_error_next     = 1'b0;
        w_data_next      = r_data;
        w_data_bits_next = r_data_bits;

        if (in_soc) begin
            // soc restarts reception from any state and overrides every other input.
            w_soc_next      = 1'b1;
            w_state_next    = ST_RX;
            w_bit_cnt_next  = 4'd0;
            w_err_flag_next = 1'b0;
            w_shreg_next    = 8'h00;
        end else if (r_state == ST_RX) begin
            if (in_eoc) begin
                w_eoc_next      = 1'b1;
                w_state_next    = ST_IDLE;
                w_bit_cnt_next  = 4'd0;
                w_err_flag_next = 1'b0;
                if (w_frame_err) begin
                    // Partial byte dropped: error must never coincide with data_valid.
                    w_error_next = 1'b1;
                end else if (r_bit_cnt != 4'd0) begin
                    w_dv_next        = 1'b1;
                    w_data_next      = r_shreg & w_mask;
                    w_data_bits_next = r_bit_cnt[2:0];
                end
            end else if (in_data_valid) begin
                if (r_bit_cnt < 4'd8) begin
                    w_shreg_next[r_bit_cnt[2:0]] = in_data;
                    w_bit_cnt_next               = r_bit_cnt + 4'd1;
                    if (!PARITY_EN && (r_bit_cnt == 4'd7)) begin
                        w_bit_cnt_next = 4'd0;
                        if (!r_err_flag) begin
                            w_dv_next        = 1'b1;
                            w_data_next      = w_shreg_next;
                            w_data_bits_next = 3'd0;
                        end
                    end
                end else begin
                    // Parity bit: a failure poisons the rest of the frame.
                    w_bit_cnt_next = 4'd0;
                    if (!w_parity_ok) begin
                        w_err_flag_next = 1'b1;
                    end else if (!r_err_flag) begin
                        w_dv_next        = 1'b1;
                        w_data_next      = r_shreg;
                        w_data_bits_next = 3'd0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= 4'd0;
            r_err_flag  <= 1'b0;
            r_shreg     <= 8'h00;
            r_soc       <= 1'b0;
            r_eoc       <= 1'b0;
            r_dv        <= 1'b0;
            r_error     <= 1'b0;
            r_data      <= 8'h00;
            r_data_bits <= 3'd0;
        end else begin
            r_state     <= w_state_next;
            r_bit_cnt   <= w_bit_cnt_next;
            r_err_flag  <= w_err_flag_next;
            r_shreg     <= w_shreg_next;
            r_soc       <= w_soc_next;
            r_eoc       <= w_eoc_next;
            r_dv        <= w_dv_next;
            r_error     <= w_error_next;
            r_data      <= w_data_next;
            r_data_bits <= w_data_bits_next;
        end
    end

    assign out_soc        = r_soc;
    assign out_eoc        = r_eoc;
    assign out_data       = r_data;
    assign out_data_valid = r_dv;
    assign out_data_bits  = r_data_bits;
    assign out_error      = r_error;

endmodule
